debug_cmd_controller: RTL and testbench
=======================================

Name: debug_cmd_controller

Overview:
Command sequencer of the debug unit. It decodes command bytes received from the UART receiver and controls the processor datapath. It loads program words into instruction memory, then runs or single-steps the pipeline. It triggers the register/memory dump sender and waits for that sender to finish before it accepts the next command.

Parameters:
UART_BITS, 8, width of one received UART byte
INSTRUCTION_BITS, 32, width of one program word (multiple of UART_BITS)
PROG_ADDRS_BITS, 10, instruction memory address width
RUN_LIMIT_BITS, 16, width of the run watchdog counter
CMD_LOAD, 8'h4C, 'L' load-program command
CMD_RUN, 8'h52, 'R' run-until-halt command
CMD_STEP, 8'h53, 'S' step command
END_WORD, 32'hFFFF_FFFF, program terminator word

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
i_rx_done  in  1  one-cycle strobe, i_rx_data valid
i_rx_data  in  UART_BITS  received byte
i_halt  in  1  processor reached HALT (level)
i_send_done  in  1  one-cycle strobe from dump sender, dump finished
o_proc_enable  out  1  datapath clock enable
o_proc_reset  out  1  one-cycle datapath reset pulse (active-high)
o_prog_write_en  out  1  instruction memory write strobe
o_prog_addr  out  PROG_ADDRS_BITS  instruction memory write address
o_prog_data  out  INSTRUCTION_BITS  instruction memory write data
o_send_start  out  1  one-cycle start pulse to dump sender
o_busy  out  1  high whenever state != IDLE
o_state  out  4  current state, for debug LEDs

Behaviour:
- Reset (async, rst=0):
  - state=IDLE.
  - All outputs 0; prog address, byte counter, word shift register and run counter cleared.
  - Reset mid-operation aborts any load, run or dump wait immediately.
- States:
  - IDLE=0, LOAD_BYTE=1, LOAD_WRITE=2, LOAD_DONE=3, RUN=4, STEP=5, ISSUE_SEND=6, WAIT_SEND=7.
- IDLE, on i_rx_done:
  - CMD_LOAD → LOAD_BYTE, with o_prog_addr=0 and byte counter=0.
  - CMD_RUN → RUN, with run counter=0.
  - CMD_STEP → STEP.
  - Any other byte is ignored; stay in IDLE.
- LOAD_BYTE:
  - Each i_rx_done shifts i_rx_data into the word register, MSB byte first, and increments the byte counter.
  - After INSTRUCTION_BITS/UART_BITS bytes → LOAD_WRITE.
- LOAD_WRITE (one cycle):
  - Drives o_prog_write_en=1 with o_prog_data=assembled word.
  - Address then increments by 1.
  - If word==END_WORD, or the address written was all-ones (no wrap-around) → LOAD_DONE; else → LOAD_BYTE with byte counter=0.
- LOAD_DONE:
  - o_proc_reset=1 for exactly one cycle, address cleared → IDLE.
- RUN:
  - o_proc_enable=1 combinationally while !i_halt and run counter != all-ones.
  - Counter increments each enabled cycle.
  - The first cycle i_halt=1 or the counter saturates: enable drops that same cycle → ISSUE_SEND.
  - If i_halt is already high on entry, zero enable cycles are issued.
- STEP:
  - o_proc_enable=1 for exactly one cycle (0 cycles if i_halt=1) → ISSUE_SEND.
- ISSUE_SEND:
  - o_send_start=1 for one cycle → WAIT_SEND.
- WAIT_SEND:
  - All control outputs 0; on i_send_done → IDLE.
  - i_send_done is ignored in every other state.
- i_rx_done in RUN, STEP, ISSUE_SEND, WAIT_SEND or LOAD_DONE: byte dropped, no state change.
- i_rx_done and i_send_done in the same cycle during WAIT_SEND: go to IDLE; the byte is dropped.
- o_proc_enable and o_prog_write_en are never high in the same cycle.

Optional Feature:
Macro DEBUG_STEP_COUNT_EN.
- Defined:
  - CMD_STEP is followed by one count byte N; the controller waits for it in STEP (no enable until it arrives).
  - Then enable is held for N cycles (N=0 treated as 1), stopping early on i_halt → ISSUE_SEND.
- Undefined:
  - CMD_STEP gives a single one-cycle step as specified above, with no extra byte consumed.

Test Plan:
- Reset mid-load after 2 bytes, release, send 'L' + 8 bytes (00 00 00 01, FF FF FF FF) → writes addr0=0x00000001 and addr1=0xFFFFFFFF, one o_proc_reset pulse, o_busy=0.
- 'R' with i_halt rising after 5 enabled cycles → exactly 5 o_proc_enable cycles, then one o_send_start; IDLE only after i_send_done.
- 'R' with i_halt stuck 0, RUN_LIMIT_BITS=4 → 15 enable cycles, then o_send_start.
- 'S' (macro undefined) → exactly 1 enable cycle, one o_send_start; a second 'S' sent during WAIT_SEND is dropped.
- 'S' + byte 0x03 (DEBUG_STEP_COUNT_EN defined) → 3 enable cycles; with i_halt=1 preset → 0 enable cycles, still one o_send_start.
- Unknown byte 0x41 in IDLE → no output activity; load of 1024 words without END_WORD → last write at addr 0x3FF, then LOAD_DONE.

Source files
------------

// File: rtl/debug_cmd_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | debug_cmd_controller                                                       |
// | Debug-unit command sequencer: program load, run, step and dump handshake.  |
// | Optional: DEBUG_STEP_COUNT_EN makes 'S' take a step-count byte.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module debug_cmd_controller #(
  parameter int                          UART_BITS        = 8,
  parameter int                          INSTRUCTION_BITS = 32,
  parameter int                          PROG_ADDRS_BITS  = 10,
  parameter int                          RUN_LIMIT_BITS   = 16,
  parameter logic [UART_BITS-1:0]        CMD_LOAD         = 8'h4C,
  parameter logic [UART_BITS-1:0]        CMD_RUN          = 8'h52,
  parameter logic [UART_BITS-1:0]        CMD_STEP         = 8'h53,
  parameter logic [INSTRUCTION_BITS-1:0] END_WORD         = 32'hFFFF_FFFF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_rx_done,
  input  logic [UART_BITS-1:0]        i_rx_data,
  input  logic                        i_halt,
  input  logic                        i_send_done,
  output logic                        o_proc_enable,
  output logic                        o_proc_reset,
  output logic                        o_prog_write_en,
  output logic [PROG_ADDRS_BITS-1:0]  o_prog_addr,
  output logic [INSTRUCTION_BITS-1:0] o_prog_data,
  output logic                        o_send_start,
  output logic                        o_busy,
  output logic [3:0]                  o_state
);

  localparam int c_BYTES = INSTRUCTION_BITS / UART_BITS;
  localparam int c_CNT_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_BYTE  = 4'd1,
    S_LOAD_WRITE = 4'd2,
    S_LOAD_DONE  = 4'd3,
    S_RUN        = 4'd4,
    S_STEP       = 4'd5,
    S_ISSUE_SEND = 4'd6,
    S_WAIT_SEND  = 4'd7
  } state_t;

  state_t                      r_state,    w_state_next;
  logic [PROG_ADDRS_BITS-1:0]  r_addr,     w_addr_next;
  logic [c_CNT_W-1:0]          r_byte_cnt, w_byte_cnt_next;
  logic [INSTRUCTION_BITS-1:0] r_word,     w_word_next;
  logic [RUN_LIMIT_BITS-1:0]   r_run_cnt,  w_run_cnt_next;
`ifdef DEBUG_STEP_COUNT_EN
  logic [UART_BITS-1:0]        r_step_cnt, w_step_cnt_next;
  logic                        r_step_armed, w_step_armed_next;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_run_cnt  <= '0;
`ifdef DEBUG_STEP_COUNT_EN
      r_step_cnt   <= '0;
      r_step_armed <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_byte_cnt <= w_byte_cnt_next;
      r_word     <= w_word_next;
      r_run_cnt  <= w_run_cnt_next;
`ifdef DEBUG_STEP_COUNT_EN
      r_step_cnt   <= w_step_cnt_next;
      r_step_armed <= w_step_armed_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_byte_cnt_next = r_byte_cnt;
    w_word_next     = r_word;
    w_run_cnt_next  = r_run_cnt;
`ifdef DEBUG_STEP_COUNT_EN
    w_step_cnt_next   = r_step_cnt;
    w_step_armed_next = r_step_armed;
`endif
    o_proc_enable   = 1'b0;
    o_proc_reset    = 1'b0;
    o_prog_write_en = 1'b0;
    o_send_start    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            w_state_next    = S_LOAD_BYTE;
            w_addr_next     = '0;
            w_byte_cnt_next = '0;
          end else if (i_rx_data == CMD_RUN) begin
            w_state_next   = S_RUN;
            w_run_cnt_next = '0;
          end else if (i_rx_data == CMD_STEP) begin
            w_state_next = S_STEP;
`ifdef DEBUG_STEP_COUNT_EN
            w_step_armed_next = 1'b0;
`endif
          end
        end
      end
      S_LOAD_BYTE: begin
        if (i_rx_done) begin
          // Big-endian assembly: the first byte ends up in the top lane.
          w_word_next     = (r_word << UART_BITS) | INSTRUCTION_BITS'(i_rx_data);
          w_byte_cnt_next = r_byte_cnt + 1'b1;
          if (r_byte_cnt == c_CNT_W'(c_BYTES - 1)) begin
            w_state_next = S_LOAD_WRITE;
          end
        end
      end
      S_LOAD_WRITE: begin
        o_prog_write_en = 1'b1;
        w_addr_next     = r_addr + 1'b1;
        if ((r_word == END_WORD) || (&r_addr)) begin
          w_state_next = S_LOAD_DONE;
        end else begin
          w_state_next    = S_LOAD_BYTE;
          w_byte_cnt_next = '0;
        end
      end
      S_LOAD_DONE: begin
        o_proc_reset = 1'b1;
        w_addr_next  = '0;
        w_state_next = S_IDLE;
      end
      S_RUN: begin
        // The watchdog stops at all-ones so a missing HALT still ends the run.
        if (i_halt || (&r_run_cnt)) begin
          w_state_next = S_ISSUE_SEND;
        end else begin
          o_proc_enable  = 1'b1;
          w_run_cnt_next = r_run_cnt + 1'b1;
        end
      end
      S_STEP: begin
`ifdef DEBUG_STEP_COUNT_EN
        if (!r_step_armed) begin
          if (i_rx_done) begin
            w_step_cnt_next   = (i_rx_data == '0) ? UART_BITS'(1) : i_rx_data;
            w_step_armed_next = 1'b1;
          end
        end else if (i_halt) begin
          w_step_armed_next = 1'b0;
          w_state_next      = S_ISSUE_SEND;
        end else begin
          o_proc_enable   = 1'b1;
          w_step_cnt_next = r_step_cnt - 1'b1;
          if (r_step_cnt == UART_BITS'(1)) begin
            w_step_armed_next = 1'b0;
            w_state_next      = S_ISSUE_SEND;
          end
        end
`else
        o_proc_enable = !i_halt;
        w_state_next  = S_ISSUE_SEND;
`endif
      end
      S_ISSUE_SEND: begin
        o_send_start = 1'b1;
        w_state_next = S_WAIT_SEND;
      end
      S_WAIT_SEND: begin
        if (i_send_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign o_prog_addr = r_addr;
  assign o_prog_data = r_word;
  assign o_busy      = (r_state != S_IDLE);
  assign o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_controller.sv
`default_nettype none
// Testbench for debug_cmd_controller: command table, hand sequences and
// randomized commands/programs checked against an event-count reference model.
module tb_debug_cmd_controller;

  localparam int         c_NEVER   = 1 << 20;
  localparam int         c_RUN_MAX = 15;
  localparam logic [7:0] c_L = 8'h4C;
  localparam logic [7:0] c_R = 8'h52;
  localparam logic [7:0] c_S = 8'h53;
`ifdef DEBUG_STEP_COUNT_EN
  localparam int c_STEP3 = 3;
`else
  localparam int c_STEP3 = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_rx_done;
  logic [7:0]  i_rx_data;
  logic        i_halt;
  logic        i_send_done;
  logic        o_proc_enable;
  logic        o_proc_reset;
  logic        o_prog_write_en;
  logic [9:0]  o_prog_addr;
  logic [31:0] o_prog_data;
  logic        o_send_start;
  logic        o_busy;
  logic [3:0]  o_state;

  always #5 clk = ~clk;

  debug_cmd_controller #(.RUN_LIMIT_BITS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rx_done      (i_rx_done),
    .i_rx_data      (i_rx_data),
    .i_halt         (i_halt),
    .i_send_done    (i_send_done),
    .o_proc_enable  (o_proc_enable),
    .o_proc_reset   (o_proc_reset),
    .o_prog_write_en(o_prog_write_en),
    .o_prog_addr    (o_prog_addr),
    .o_prog_data    (o_prog_data),
    .o_send_start   (o_send_start),
    .o_busy         (o_busy),
    .o_state        (o_state)
  );

  typedef struct {
    logic [7:0] cmd;
    int         h;
    logic [7:0] n;
    int         mode;
    int         exp_en;
    int         exp_st;
  } vec_t;

  vec_t        tbl[10];
  int          total = 0;
  int          bad = 0;
  int          en_cnt, st_cnt, rs_cnt, wr_cnt, overlap_cnt = 0;
  int          halt_after = c_NEVER;
  logic [9:0]  last_addr;
  logic [31:0] mem_seen[1024];
  bit          written[1024];
  logic [31:0] prog_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    en_cnt = 0; st_cnt = 0; rs_cnt = 0; wr_cnt = 0;
    for (int i = 0; i < 1024; i++) written[i] = 1'b0;
  endtask

  // One clock: drive inputs just after the edge, sample outputs mid-cycle.
  task automatic cyc(input logic rxd, input logic [7:0] d, input logic sd);
    @(posedge clk);
    #1;
    i_rx_done   = rxd;
    i_rx_data   = d;
    i_send_done = sd;
    i_halt      = (en_cnt >= halt_after);
    @(negedge clk);
    if (o_proc_enable) en_cnt++;
    if (o_send_start) st_cnt++;
    if (o_proc_reset) rs_cnt++;
    if (o_proc_enable && o_prog_write_en) overlap_cnt++;
    if (o_prog_write_en) begin
      wr_cnt++;
      mem_seen[o_prog_addr] = o_prog_data;
      written[o_prog_addr]  = 1'b1;
      last_addr             = o_prog_addr;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  // Reference: enabled cycles = min(halt delay, command's cycle limit).
  function automatic int model_en(input logic [7:0] cmd, input int h, input logic [7:0] n);
    int lim;
    if (cmd == c_R) lim = c_RUN_MAX;
`ifdef DEBUG_STEP_COUNT_EN
    else if (cmd == c_S) lim = (n == 8'd0) ? 1 : int'(n);
`else
    else if (cmd == c_S) lim = 1;
`endif
    else return 0;
    return (h < lim) ? h : lim;
  endfunction

  function automatic int model_st(input logic [7:0] cmd);
    return (cmd == c_R || cmd == c_S) ? 1 : 0;
  endfunction

  // mode 0: plain send_done; 1: stray 'S' in WAIT_SEND first; 2: 'S' with send_done.
  task automatic run_scn(input string name, input logic [7:0] cmd, input int h,
                         input logic [7:0] n, input int mode, input int exp_en, input int exp_st);
    int k;
    clr_counts();
    halt_after = h;
    cyc(1'b1, cmd, 1'b0);
`ifdef DEBUG_STEP_COUNT_EN
    if (cmd == c_S) begin
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, n, 1'b0);
    end
`endif
    if (exp_st != 0) begin
      k = 0;
      while (st_cnt == 0 && k < 60) begin
        cyc(1'b0, 8'h00, 1'b0);
        k++;
      end
      chk({name, " start_seen"}, st_cnt, 1);
      repeat (3) cyc(1'b0, 8'h00, 1'b0);
      chk({name, " wait_send_busy"}, {o_busy, o_state}, {1'b1, 4'd7});
      if (mode == 1) begin
        cyc(1'b1, c_S, 1'b0);
        repeat (2) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
      end else if (mode == 2) begin
        cyc(1'b1, c_S, 1'b1);
      end else begin
        cyc(1'b0, 8'h00, 1'b1);
      end
    end
    repeat (6) cyc(1'b0, 8'h00, 1'b0);
    chk({name, " idle_state"}, {o_busy, o_state}, 5'd0);
    chk({name, " enable_cycles"}, en_cnt, exp_en);
    chk({name, " send_starts"}, st_cnt, exp_st);
    halt_after = c_NEVER;
  endtask

  task automatic do_load(input string name);
    int nexp;
    int errs;
    int k;
    logic [31:0] w;
    nexp = 0;
    for (int i = 0; i < prog_q.size() && nexp < 1024; i++) begin
      nexp++;
      if (prog_q[i] == 32'hFFFF_FFFF) break;
    end
    clr_counts();
    send_byte(c_L);
    for (int i = 0; i < nexp; i++) begin
      w = prog_q[i];
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
    end
    k = 0;
    while (rs_cnt == 0 && k < 10) begin
      cyc(1'b0, 8'h00, 1'b0);
      k++;
    end
    cyc(1'b0, 8'h00, 1'b0);
    errs = 0;
    for (int i = 0; i < nexp; i++)
      if (!written[i] || mem_seen[i] !== prog_q[i]) errs++;
    chk({name, " write_count"}, wr_cnt, nexp);
    chk({name, " word_errors"}, errs, 0);
    chk({name, " last_addr"}, last_addr, nexp - 1);
    chk({name, " proc_reset_pulses"}, rs_cnt, 1);
    chk({name, " idle_addr_cleared"}, {o_busy, o_state, o_prog_addr}, 15'd0);
  endtask

  initial begin
    tbl[0] = '{8'h41, c_NEVER, 8'd0, 0, 0, 0};
    tbl[1] = '{c_R, 5, 8'd0, 0, 5, 1};
    tbl[2] = '{c_R, 0, 8'd0, 0, 0, 1};
    tbl[3] = '{c_R, c_NEVER, 8'd0, 0, 15, 1};
    tbl[4] = '{c_R, 14, 8'd0, 2, 14, 1};
    tbl[5] = '{c_S, c_NEVER, 8'd3, 1, c_STEP3, 1};
    tbl[6] = '{c_S, 0, 8'd3, 0, 0, 1};
    tbl[7] = '{c_S, c_NEVER, 8'd0, 0, 1, 1};
    tbl[8] = '{8'h00, 0, 8'd0, 0, 0, 0};
    tbl[9] = '{c_S, 2, 8'd5, 2, (c_STEP3 == 3) ? 2 : 1, 1};

    rst = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00; i_halt = 1'b0; i_send_done = 1'b0;
    en_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_proc_enable, o_proc_reset, o_prog_write_en, o_prog_addr,
                          o_prog_data, o_send_start, o_busy, o_state}, 0);
    rst = 1'b1;

    // Reset in the middle of a load, then a clean two-word load.
    clr_counts();
    send_byte(c_L);
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("mid_load_busy", o_busy, 1);
    rst = 1'b0;
    #1;
    chk("async_reset_abort", {o_busy, o_state, o_prog_addr, o_prog_data}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    prog_q = '{32'h0000_0001, 32'hFFFF_FFFF};
    do_load("load_two");
    chk("load_two_word0", mem_seen[0], 32'h0000_0001);
    chk("load_two_word1", mem_seen[1], 32'hFFFF_FFFF);

    for (int i = 0; i < 10; i++)
      run_scn($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].h, tbl[i].n, tbl[i].mode,
              tbl[i].exp_en, tbl[i].exp_st);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] cmd;
      int sel;
      int h;
      logic [7:0] n;
      sel = $urandom_range(0, 3);
      cmd = (sel == 0) ? c_R : (sel == 1) ? c_S : 8'($urandom);
      if (cmd == c_L) cmd = 8'h00;
      h = $urandom_range(0, 20);
      n = 8'($urandom_range(0, 6));
      run_scn($sformatf("rnd%0d", i), cmd, h, n, $urandom_range(0, 2),
              model_en(cmd, h, n), model_st(cmd));
    end

    for (int i = 0; i < 5; i++) begin
      logic [31:0] w;
      prog_q = {};
      repeat ($urandom_range(0, 5)) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        prog_q.push_back(w);
      end
      prog_q.push_back(32'hFFFF_FFFF);
      do_load($sformatf("rndload%0d", i));
    end

    prog_q = {};
    for (int i = 0; i < 1024; i++) prog_q.push_back(32'(i) ^ 32'h5A00_0000);
    do_load("load_full");

    chk("enable_write_exclusive", overlap_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
